// File: rtl/othello_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | othello_pkg: board/score types and dispatcher FSM states.  Rev 1.0         |
// +--------------------------------------------------------------------------+
package othello_pkg;

  typedef logic [63:0]        board_t;
  typedef logic signed [7:0]  score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/task_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | task_fifo: count-based synchronous FIFO for pending solver tasks. Rev 1.0  |
// +--------------------------------------------------------------------------+
module task_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 136
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define content.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/solver_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | solver_dispatcher: queues boards, drives the solver, returns results. 1.0  |
// +--------------------------------------------------------------------------+
module solver_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int ID_W    = 8,
  parameter int CYC_W   = 32,
  parameter int TIMEOUT = 10_000_000,
  parameter int GAP     = 2
) (
  input  logic                iCLOCK,
  input  logic                iRESET_N,
  input  logic                iTaskValid,
  output logic                oTaskReady,
  input  logic [63:0]         iTaskPlayer,
  input  logic [63:0]         iTaskOpponent,
  input  logic [ID_W-1:0]     iTaskId,
  output logic                oEnable,
  output logic [63:0]         oPlayer,
  output logic [63:0]         oOpponent,
  input  logic                iSolved,
  input  logic signed [7:0]   iRes,
  output logic                oResValid,
  input  logic                iResReady,
  output logic [ID_W-1:0]     oResId,
  output logic signed [7:0]   oResScore,
  output logic                oResTimeout,
  output logic                oResInvalid,
  output logic [CYC_W-1:0]    oResCycles,
  output logic                oBusy
);

  import othello_pkg::*;

  localparam int               FIFO_W    = 128 + ID_W;
  localparam int               GAP_W     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);

  disp_state_e       state;
  logic [FIFO_W-1:0] head;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  board_t            head_player;
  board_t            head_opponent;
  logic [ID_W-1:0]   head_id;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CYC_W-1:0]  run_cnt;

  task_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (iCLOCK),
    .rst_n (iRESET_N),
    .push  (iTaskValid),
    .wdata ({iTaskPlayer, iTaskOpponent, iTaskId}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_player, head_opponent, head_id} = head;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign oTaskReady = !fifo_full;
  assign oBusy      = (state != IDLE) || !fifo_empty;

  always_ff @(posedge iCLOCK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      run_cnt     <= '0;
      oEnable     <= 1'b0;
      oPlayer     <= '0;
      oOpponent   <= '0;
      oResValid   <= 1'b0;
      oResId      <= '0;
      oResScore   <= '0;
      oResTimeout <= 1'b0;
      oResInvalid <= 1'b0;
      oResCycles  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            oResId      <= head_id;
            oResTimeout <= 1'b0;
            // Overlapping stones can never be a legal position: report without solving.
            if ((head_player & head_opponent) != '0) begin
              oResInvalid <= 1'b1;
              oResScore   <= '0;
              oResCycles  <= '0;
              oResValid   <= 1'b1;
              state       <= DONE;
            end else begin
              oResInvalid <= 1'b0;
              oPlayer     <= head_player;
              oOpponent   <= head_opponent;
              gap_cnt     <= '0;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (gap_cnt == GAP_LAST) begin
            oEnable <= 1'b1;
            run_cnt <= CYC_W'(1);
            state   <= RUN;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        RUN: begin
          // A solve landing on the timeout cycle still counts as solved.
          if (iSolved) begin
            oResScore  <= iRes;
            oResCycles <= run_cnt;
            oEnable    <= 1'b0;
            oResValid  <= 1'b1;
            state      <= DONE;
          end else if (run_cnt == CYC_LIMIT) begin
            oResScore   <= '0;
            oResCycles  <= run_cnt;
            oResTimeout <= 1'b1;
            oEnable     <= 1'b0;
            oResValid   <= 1'b1;
            state       <= DONE;
          end else if (run_cnt != '1) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        DONE: begin
          if (iResReady) begin
            oResValid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_solver_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_solver_dispatcher: randomized bench with task-level reference model.   |
// +--------------------------------------------------------------------------+
module tb_solver_dispatcher;

  localparam int DEPTH = 4;
  localparam int ID_W  = 8;
  localparam int CYC_W = 32;
  localparam int T     = 128;
  localparam int GAP   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               iTaskValid = 1'b0;
  logic               oTaskReady;
  logic [63:0]        iTaskPlayer;
  logic [63:0]        iTaskOpponent;
  logic [ID_W-1:0]    iTaskId;
  logic               oEnable;
  logic [63:0]        oPlayer;
  logic [63:0]        oOpponent;
  logic               iSolved;
  logic signed [7:0]  iRes;
  logic               oResValid;
  logic               iResReady = 1'b0;
  logic [ID_W-1:0]    oResId;
  logic signed [7:0]  oResScore;
  logic               oResTimeout;
  logic               oResInvalid;
  logic [CYC_W-1:0]   oResCycles;
  logic               oBusy;

  solver_dispatcher #(
    .DEPTH(DEPTH), .ID_W(ID_W), .CYC_W(CYC_W), .TIMEOUT(T), .GAP(GAP)
  ) dut (
    .iCLOCK(clk), .iRESET_N(rst_n),
    .iTaskValid(iTaskValid), .oTaskReady(oTaskReady),
    .iTaskPlayer(iTaskPlayer), .iTaskOpponent(iTaskOpponent), .iTaskId(iTaskId),
    .oEnable(oEnable), .oPlayer(oPlayer), .oOpponent(oOpponent),
    .iSolved(iSolved), .iRes(iRes),
    .oResValid(oResValid), .iResReady(iResReady), .oResId(oResId),
    .oResScore(oResScore), .oResTimeout(oResTimeout), .oResInvalid(oResInvalid),
    .oResCycles(oResCycles), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  // k = RUN cycle on which the solver answers; 0 means it never answers.
  typedef struct {
    logic [63:0] p;
    logic [63:0] o;
    logic [7:0]  id;
    int          k;
    logic [7:0]  res;
  } task_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task_t       offer;
  task_t       q[$];
  task_t       cur;
  bit          cur_on = 1'b0;
  int          age = 0;
  logic [63:0] last_p = '0;
  logic [63:0] last_o = '0;
  bit          m_idle_pre;
  int          m_size_pre;

  assign iTaskPlayer   = offer.p;
  assign iTaskOpponent = offer.o;
  assign iTaskId       = offer.id;

  function automatic int run_len(input task_t t);
    return (t.k == 0) ? T : t.k;
  endfunction

  function automatic bit is_inv(input task_t t);
    return (t.p & t.o) != 64'd0;
  endfunction

  // Age = edges since the task left the queue; output windows follow from it.
  function automatic bit m_en();
    return cur_on && !is_inv(cur) && age >= GAP && age < GAP + run_len(cur);
  endfunction

  function automatic bit m_valid();
    return cur_on && (is_inv(cur) || age >= GAP + run_len(cur));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur_on = 1'b0;
      age    = 0;
      last_p = '0;
      last_o = '0;
    end else begin
      m_idle_pre = !cur_on;
      m_size_pre = q.size();
      if (m_valid() && iResReady) cur_on = 1'b0;
      else if (cur_on) age++;
      if (m_idle_pre && m_size_pre > 0) begin
        cur    = q.pop_front();
        cur_on = 1'b1;
        age    = 0;
        if (!is_inv(cur)) begin
          last_p = cur.p;
          last_o = cur.o;
        end
      end
      if (iTaskValid && m_size_pre < DEPTH) q.push_back(offer);
    end
  end

  // Solver stand-in: answers on its k-th enabled cycle, random noise otherwise.
  int run_cnt = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt = 0;
      iSolved = 1'b0;
      iRes    = '0;
    end else if (oEnable) begin
      run_cnt++;
      iSolved = cur_on && cur.k != 0 && run_cnt == cur.k;
      iRes    = iSolved ? cur.res : 8'($urandom);
    end else begin
      run_cnt = 0;
      iSolved = ($urandom_range(0, 3) == 0);
      iRes    = 8'($urandom);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("enable", oEnable, m_en());
      chk("player", oPlayer, last_p);
      chk("opponent", oOpponent, last_o);
      chk("task_ready", oTaskReady, q.size() < DEPTH);
      chk("busy", oBusy, cur_on || q.size() > 0);
      chk("res_valid", oResValid, m_valid());
      if (m_valid()) begin
        chk("res_id", oResId, cur.id);
        chk("res_invalid", oResInvalid, is_inv(cur));
        if (is_inv(cur)) begin
          chk("res_score", oResScore, 0);
          chk("res_cycles", oResCycles, 0);
          chk("res_timeout", oResTimeout, 0);
        end else if (cur.k != 0) begin
          chk("res_score", {56'd0, oResScore}, {56'd0, cur.res});
          chk("res_cycles", oResCycles, cur.k);
          chk("res_timeout", oResTimeout, 0);
        end else begin
          chk("res_score", oResScore, 0);
          chk("res_cycles", oResCycles, T);
          chk("res_timeout", oResTimeout, 1);
        end
      end
    end
  end

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic push_task(input logic [63:0] p, input logic [63:0] o, input logic [7:0] id,
                           input int k, input logic [7:0] res);
    int g;
    offer.p = p; offer.o = o; offer.id = id; offer.k = k; offer.res = res;
    iTaskValid = 1'b1;
    g = 0;
    while (!oTaskReady && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("push_accept", oTaskReady, 1);
    @(negedge clk);
    iTaskValid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    while (!oResValid && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk(name, oResValid, 1);
  endtask

  task automatic handshake();
    iResReady = 1'b1;
    @(negedge clk);
    iResReady = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_enable"}, oEnable, 0);
    chk({tag, "_player"}, oPlayer, 0);
    chk({tag, "_opponent"}, oOpponent, 0);
    chk({tag, "_valid"}, oResValid, 0);
    chk({tag, "_id"}, oResId, 0);
    chk({tag, "_score"}, oResScore, 0);
    chk({tag, "_timeout"}, oResTimeout, 0);
    chk({tag, "_invalid"}, oResInvalid, 0);
    chk({tag, "_cycles"}, oResCycles, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_ready"}, oTaskReady, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          low;
    int          g;
    int          acc;
    bit          saw;
    bit          stable;
    bit          acc_now;
    bit          rdy_prev;
    logic [7:0]  nid;
    logic [63:0] p;
    logic [63:0] o;
    logic [7:0]  got[$];
    int          r;
    int          k;

    offer.p = '0; offer.o = '0; offer.id = '0; offer.k = 0; offer.res = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single task: 100 RUN cycles, score 16, ID 05.
    push_task(64'h10B8DDE3B1B98284, 64'h8E45221C4E467C78, 8'h05, 100, 8'd16);
    low = 0;
    g = 0;
    while (!oEnable && g < 300) begin
      if (oPlayer == 64'h10B8DDE3B1B98284 && oOpponent == 64'h8E45221C4E467C78) low++;
      @(negedge clk);
      g++;
    end
    chk("gap_cycles", low, 2);
    wait_valid("single_valid");
    chk("single_score", {56'd0, oResScore}, 64'd16);
    chk("single_id", oResId, 8'h05);
    chk("single_cycles", oResCycles, 100);
    chk("single_timeout", oResTimeout, 0);
    chk("single_enable_low", oEnable, 0);
    handshake();
    chk("single_released", oResValid, 0);

    // Overlapping stones: rejected without enabling the solver.
    push_task(64'h1, 64'h1, 8'h22, 5, 8'd9);
    saw = 1'b0;
    g = 0;
    while (!oResValid && g < 100) begin
      if (oEnable) saw = 1'b1;
      @(negedge clk);
      g++;
    end
    chk("invalid_valid", oResValid, 1);
    chk("invalid_no_enable", saw, 0);
    chk("invalid_flag", oResInvalid, 1);
    chk("invalid_score", oResScore, 0);
    chk("invalid_cycles", oResCycles, 0);
    chk("invalid_id", oResId, 8'h22);
    handshake();

    // Never solved: abort at TIMEOUT.
    p = rand64();
    push_task(p, rand64() & ~p, 8'h31, 0, 8'd33);
    wait_valid("timeout_valid");
    chk("timeout_flag", oResTimeout, 1);
    chk("timeout_cycles", oResCycles, 128);
    chk("timeout_score", oResScore, 0);
    handshake();

    // Solved on the timeout cycle itself: solve wins.
    p = rand64();
    push_task(p, rand64() & ~p, 8'h32, T, 8'hF9);
    wait_valid("edge_valid");
    chk("edge_timeout", oResTimeout, 0);
    chk("edge_score", {56'd0, oResScore}, 64'hF9);
    chk("edge_cycles", oResCycles, 128);
    handshake();

    // FIFO full with results held back.
    acc = 0;
    for (int id = 1; id <= 6; id++) begin
      p = rand64();
      offer.p = p; offer.o = rand64() & ~p; offer.id = 8'(id); offer.k = 3 + id;
      offer.res = 8'(id * 3);
      iTaskValid = 1'b1;
      if (!oTaskReady) break;
      acc++;
      @(negedge clk);
    end
    if (acc == 6) iTaskValid = 1'b0;
    chk("fifo_accepts", acc, 5);
    wait_valid("bp_valid");
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!(oResValid && oResId == 8'd1 && oResCycles == 32'd4 && !oEnable && !oTaskReady))
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    iResReady = 1'b1;
    g = 0;
    while (got.size() < 6 && g < 2000) begin
      if (oResValid) got.push_back(oResId);
      acc_now = iTaskValid && oTaskReady;
      @(negedge clk);
      if (acc_now) iTaskValid = 1'b0;
      g++;
    end
    chk("order_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("order_id", (i < got.size()) ? got[i] : 8'hFF, 8'(i + 1));

    // Randomized traffic with random downstream backpressure.
    nid = 8'h80;
    rdy_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (iTaskValid && rdy_prev) iTaskValid = 1'b0;
      if (!iTaskValid && $urandom_range(0, 1) == 0) begin
        r = $urandom_range(0, 19);
        p = rand64();
        o = (r == 0) ? (rand64() | p) : (rand64() & ~p);
        k = (r == 1) ? 0 : (r == 2) ? T : (r == 3) ? $urandom_range(1, T) : $urandom_range(1, 12);
        offer.p = p; offer.o = o; offer.id = nid; offer.k = k; offer.res = 8'($urandom);
        nid = nid + 8'd1;
        iTaskValid = 1'b1;
      end
      iResReady = ($urandom_range(0, 9) < 6);
      rdy_prev = oTaskReady;
      @(negedge clk);
    end
    iResReady = 1'b1;
    g = 0;
    while ((iTaskValid || oBusy || oResValid) && g < 5000) begin
      acc_now = iTaskValid && oTaskReady;
      @(negedge clk);
      if (acc_now) iTaskValid = 1'b0;
      g++;
    end
    chk("drain_idle", {oBusy, oResValid}, 0);

    // Asynchronous reset in the middle of RUN with tasks still queued.
    iResReady = 1'b0;
    p = rand64();
    push_task(p, rand64() & ~p, 8'h40, 0, 8'd1);
    g = 0;
    while (!oEnable && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("rst_run_reached", oEnable, 1);
    p = rand64();
    push_task(p, rand64() & ~p, 8'h41, 3, 8'd2);
    p = rand64();
    push_task(p, rand64() & ~p, 8'h42, 3, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    iResReady = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (oResValid || oEnable || oBusy) saw = 1'b1;
    end
    chk("post_reset_quiet", saw, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/solver_dispatcher.md
# solver_dispatcher

Feeds Othello endgame positions into the `pipeline` solver and collects its answers. Sits directly upstream of `pipeline`: it buffers incoming (player, opponent) boards in a small FIFO, presents one board at a time with `enable`, and waits for `solved`. It then returns the score, an ID tag and the cycle count to a downstream consumer over a valid/ready result port. It also enforces a per-task cycle timeout.

## Interface
- `DEPTH`, 4: input FIFO entries (power of two, ≥2)
- `ID_W`, 8: task ID width
- `CYC_W`, 32: cycle-counter width
- `TIMEOUT`, 10_000_000: maximum RUN cycles per task before abort
- `GAP`, 2: cycles `oEnable` is held low with the new board stable before RUN (≥1)

Ports:
- `iCLOCK`  in  1  sole clock; all logic on posedge
- `iRESET_N`  in  1  asynchronous, active-low reset
- `iTaskValid`  in  1  upstream task offer
- `oTaskReady`  out  1  FIFO not full
- `iTaskPlayer`  in  64  side-to-move stones
- `iTaskOpponent`  in  64  opponent stones
- `iTaskId`  in  ID_W  tag echoed on result
- `oEnable`  out  1  to `pipeline.enable`
- `oPlayer`  out  64  to `pipeline.iPlayer`
- `oOpponent`  out  64  to `pipeline.iOpponent`
- `iSolved`  in  1  from `pipeline.solved`
- `iRes`  in  8 signed  from `pipeline.res`
- `oResValid`  out  1  result available
- `iResReady`  in  1  downstream accepts result
- `oResId`  out  ID_W  task tag
- `oResScore`  out  8 signed  final disc differential
- `oResTimeout`  out  1  task aborted by TIMEOUT
- `oResInvalid`  out  1  board rejected (overlapping stones)
- `oResCycles`  out  CYC_W  RUN cycles consumed
- `oBusy`  out  1  FSM not IDLE or FIFO not empty

## Operation
- Task push: occurs when `iTaskValid && oTaskReady`. `oTaskReady = !full`. A push and a pop in the same cycle are legal unless the FIFO is full; when full, `oTaskReady` is low and the pop does not re-open it until the next cycle.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: when the FIFO is non-empty, pop the head.
  - If `player & opponent != 0`: register the result with `oResInvalid=1`, score 0, cycles 0, and go to DONE. The solver is never enabled.
  - Otherwise: register `oPlayer`/`oOpponent` and the ID, then go to LOAD.
- LOAD: `oEnable=0`. A counter runs GAP cycles, then the FSM goes to RUN.
- RUN: `oEnable=1`, and the board is held stable. The cycle counter starts at 1 on the first RUN cycle and increments each cycle.
  - `iSolved=1`: capture `iRes` as the score and the counter as cycles, then go to DONE.
  - Counter == TIMEOUT with no `iSolved`: score 0, `oResTimeout=1`, go to DONE.
  - If `iSolved` arrives on the same cycle the counter reaches TIMEOUT, `iSolved` wins and timeout stays 0.
- DONE: `oEnable=0`, `oResValid=1`. All result fields stay stable until `iResReady`. On handshake, go to IDLE.
- `iSolved` is ignored outside RUN.
- `oEnable` is registered (no combinational path from inputs).
- Cycle counter saturates at its all-ones value and never wraps.
- Reset mid-task: FSM returns to IDLE, the FIFO is emptied, and any in-flight task and pending result are discarded.

## Timing
- Reset values:
  - `oEnable=0`, `oPlayer=0`, `oOpponent=0`
  - `oResValid=0`, `oResId=0`, `oResScore=0`
  - `oResTimeout=0`, `oResInvalid=0`, `oResCycles=0`
  - `oBusy=0`, `oTaskReady=1`
- Push at posedge N: FIFO becomes non-empty at N+1. The pop happens at N+1 and enters LOAD. Board outputs are valid from N+2. `oEnable` rises at N+2+GAP.
- `iSolved` sampled at edge S: `oResValid` goes high from S+1 and `oEnable` goes low from S+1.
- Handshake at edge H: the next FIFO pop happens at H+1 at the earliest, so back-to-back tasks are separated by ≥GAP+2 cycles with `oEnable` low.
- `oBusy` is combinational from FSM state and FIFO empty.

## Structure
- Shared package `othello_pkg`: `board_t` (logic [63:0]), `score_t` (logic signed [7:0]), and the FSM state enum `disp_state_e`.
- One sub-module, `task_fifo`: a synchronous FIFO, DEPTH × (64+64+ID_W), with count-based full/empty and the same asynchronous active-low reset. The dispatcher FSM, counters and result registers live in `solver_dispatcher`.

## Test plan
- Single task: player 64'h10B8DDE3B1B98284, opponent 64'h8E45221C4E467C78, ID 8'h05. A solver model asserts `solved` with res=16 after 100 RUN cycles. Required: `oResScore=16`, `oResId=05`, `oResCycles=100`, and `oEnable` low for exactly GAP cycles before RUN.
- Invalid board: player 64'h1, opponent 64'h1. Required: `oResInvalid=1` with no `oEnable` pulse.
- Timeout: run with TIMEOUT=50 and a model that never solves. Required: `oResTimeout=1`, `oResCycles=50`, score 0. Also drive `iSolved` on cycle 50 only; required: timeout=0 and the score is taken from `iRes`.
- FIFO full: push DEPTH+2 tasks (IDs 1..6) while holding `iResReady=0`. Required: `oTaskReady` drops after DEPTH+1 accepts (one task is in flight), and results come out in ID order 1..N with no loss.
- Backpressure: hold `iResReady=0` for 20 cycles. Required: result fields stay stable, `oEnable` stays 0, and no pop occurs.
- Reset mid-RUN: pulse `iRESET_N` low asynchronously. Required: all outputs go immediately to reset values, the FIFO is empty, and no stale result appears afterwards.
